// File: rtl/memoria_dados_param.sv
// -----------------------------------------------------------------------------
// memoria_dados_param
//
// Parametrised, pipelined data memory for the nRisc/mRisc processors. It
// accepts one read and/or one write per cycle while Pronto is high and returns
// read data through a READ_LAT-deep valid/data pipeline.
//
// Optional feature macro: MEM_CLEAR_ON_RESET_EN
//   defined   : after reset a CLEAR state writes 0 to every word, one per cycle,
//               and only then raises Pronto (DEPTH cycles after reset release).
//   undefined : Pronto rises at the first rising edge after reset release;
//               unwritten words are undefined.
//
// Parameters:
//   DATA_W    data word width
//   ADDR_W    address width
//   DEPTH     number of words (1 .. 2**ADDR_W)
//   READ_LAT  read latency in cycles (1 .. 4)
//
// Ports:
//   Clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   EscMem       in   write request
//   LerMem       in   read request
//   Endereco     in   word address
//   EscreveDado  in   write data
//   LeDado       out  read data, holds its last value between responses
//   LeValido     out  one-cycle pulse marking LeDado valid
//   Pronto       out  memory accepts requests
//   ErroEnd      out  one-cycle pulse on an out-of-range access
//   estado_dbg   out  current FSM state (1 = RUN)
//
// Handshake: a request is taken on a rising edge where Pronto=1 and EscMem or
// LerMem is high; with Pronto=0 requests are dropped, never queued. Each
// accepted read produces exactly one LeValido pulse READ_LAT cycles after the
// accept edge, in accept order; there is no back-pressure on the response.
// Writes produce no response strobe.
// -----------------------------------------------------------------------------
module memoria_dados_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 256,
   parameter int READ_LAT = 1
) (
   input  logic              Clock,
   input  logic              reset,
   input  logic              EscMem,
   input  logic              LerMem,
   input  logic [ADDR_W-1:0] Endereco,
   input  logic [DATA_W-1:0] EscreveDado,
   output logic [DATA_W-1:0] LeDado,
   output logic              LeValido,
   output logic              Pronto,
   output logic              ErroEnd,
   output logic [0:0]        estado_dbg
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LAST  = READ_LAT - 1;

   // The reset encoding is CLEAR when the clear sequencer is built in; in the
   // default build it is only a one-cycle hold that moves straight to RUN.
`ifdef MEM_CLEAR_ON_RESET_EN
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RESET = ST_CLEAR;
`else
   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_RESET = ST_INIT;
`endif
   localparam logic [0:0] ST_RUN   = 1'b1;

   // Elaboration-time parameter checks.
   if ((READ_LAT < 1) || (READ_LAT > 4)) begin : g_bad_read_lat
      $error("memoria_dados_param: READ_LAT=%0d outside 1..4", READ_LAT);
   end
   if ((DEPTH < 1) || (longint'(DEPTH) > (longint'(1) << ADDR_W))) begin : g_bad_depth
      $error("memoria_dados_param: DEPTH=%0d does not fit ADDR_W=%0d", DEPTH, ADDR_W);
   end

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic [0:0]        state_q, state_d;
   logic [LAST:0]     pipe_vld_q, pipe_vld_d;
   logic [LAST:0]     pipe_err_q, pipe_err_d;
   logic [DATA_W-1:0] pipe_dat_q [READ_LAT];
   logic [DATA_W-1:0] pipe_dat_d [READ_LAT];
   logic [DATA_W-1:0] le_dado_q, le_dado_d;
   logic              le_valido_q, le_valido_d;
   logic              erro_end_q, erro_end_d;
   logic              wr_err_q, wr_err_d;
`ifdef MEM_CLEAR_ON_RESET_EN
   logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
`endif

   logic              pronto;
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              acc_wr;
   logic              acc_rd;
   logic [DATA_W-1:0] rd_word;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Request decode and array read port. The read is combinational from the
   // array so the sample taken at the accept edge sees pre-write contents.
   always_comb begin
      pronto   = (state_q == ST_RUN);
      in_range = ({1'b0, Endereco} < (ADDR_W + 1)'(DEPTH));
      idx      = Endereco[IDX_W-1:0];
      acc_wr   = pronto & EscMem;
      acc_rd   = pronto & LerMem;
      rd_word  = in_range ? mem[idx] : '0;
   end

   // FSM and array write port mux (clear sequencer has priority while active).
   always_comb begin
      state_d   = state_q;
      mem_we    = acc_wr & in_range;
      mem_waddr = idx;
      mem_wdata = EscreveDado;
`ifdef MEM_CLEAR_ON_RESET_EN
      clr_cnt_d = clr_cnt_q;
`endif
      case (state_q)
         ST_RESET: begin
`ifdef MEM_CLEAR_ON_RESET_EN
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
               clr_cnt_d = '0;
               state_d   = ST_RUN;
            end
`else
            state_d = ST_RUN;
`endif
         end
         default: state_d = state_q;
      endcase
   end

   // Read response pipeline: stage 0 captures the array sample at the accept
   // edge, the output registers add the final cycle of latency.
   always_comb begin
      pipe_vld_d[0] = acc_rd;
      pipe_err_d[0] = acc_rd & ~in_range;
      pipe_dat_d[0] = rd_word;
      for (int k = 1; k < READ_LAT; k++) begin
         pipe_vld_d[k] = pipe_vld_q[k-1];
         pipe_err_d[k] = pipe_err_q[k-1];
         pipe_dat_d[k] = pipe_dat_q[k-1];
      end
      wr_err_d    = acc_wr & ~in_range;
      le_valido_d = pipe_vld_q[LAST];
      le_dado_d   = pipe_vld_q[LAST] ? pipe_dat_q[LAST] : le_dado_q;
      // A write error is reported one cycle after its accept edge; a read
      // error rides with the read's LeValido.
      erro_end_d  = (pipe_vld_q[LAST] & pipe_err_q[LAST]) | wr_err_q;
   end

   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RESET;
         pipe_vld_q  <= '0;
         pipe_err_q  <= '0;
         for (int k = 0; k < READ_LAT; k++) pipe_dat_q[k] <= '0;
         le_dado_q   <= '0;
         le_valido_q <= 1'b0;
         erro_end_q  <= 1'b0;
         wr_err_q    <= 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
         clr_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_err_q  <= pipe_err_d;
         for (int k = 0; k < READ_LAT; k++) pipe_dat_q[k] <= pipe_dat_d[k];
         le_dado_q   <= le_dado_d;
         le_valido_q <= le_valido_d;
         erro_end_q  <= erro_end_d;
         wr_err_q    <= wr_err_d;
`ifdef MEM_CLEAR_ON_RESET_EN
         clr_cnt_q   <= clr_cnt_d;
`endif
      end
   end

   // Array storage has no reset; contents survive a reset unless CLEAR runs.
   always_ff @(posedge Clock) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign LeDado     = le_dado_q;
   assign LeValido   = le_valido_q;
   assign ErroEnd    = erro_end_q;
   assign Pronto     = pronto;
   assign estado_dbg = state_q;

endmodule

// File: tb/tb_memoria_dados_param.sv
// -----------------------------------------------------------------------------
// tb_memoria_dados_param
//
// Three instances share one clock:
//   inst 0 : DEPTH=16,  READ_LAT=1
//   inst 1 : DEPTH=200, READ_LAT=3
//   inst 2 : DEPTH=16,  READ_LAT=4
// Read expectations (instance, data, error flag, due cycle) are queued when a
// read is driven and checked by a negedge monitor when LeValido pulses.
// -----------------------------------------------------------------------------
module tb_memoria_dados_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef MEM_CLEAR_ON_RESET_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic       rst       [3];
   logic       esc       [3];
   logic       ler       [3];
   logic [7:0] addr      [3];
   logic [7:0] wdat      [3];
   logic [7:0] le_dado   [3];
   logic       le_valido [3];
   logic       pronto    [3];
   logic       erro_end  [3];
   logic [0:0] dbg       [3];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   memoria_dados_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .READ_LAT(1)) u_a (
      .Clock(clk), .reset(rst[0]), .EscMem(esc[0]), .LerMem(ler[0]),
      .Endereco(addr[0]), .EscreveDado(wdat[0]), .LeDado(le_dado[0]),
      .LeValido(le_valido[0]), .Pronto(pronto[0]), .ErroEnd(erro_end[0]),
      .estado_dbg(dbg[0]));

   memoria_dados_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .READ_LAT(3)) u_b (
      .Clock(clk), .reset(rst[1]), .EscMem(esc[1]), .LerMem(ler[1]),
      .Endereco(addr[1]), .EscreveDado(wdat[1]), .LeDado(le_dado[1]),
      .LeValido(le_valido[1]), .Pronto(pronto[1]), .ErroEnd(erro_end[1]),
      .estado_dbg(dbg[1]));

   memoria_dados_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .READ_LAT(4)) u_c (
      .Clock(clk), .reset(rst[2]), .EscMem(esc[2]), .LerMem(ler[2]),
      .Endereco(addr[2]), .EscreveDado(wdat[2]), .LeDado(le_dado[2]),
      .LeValido(le_valido[2]), .Pronto(pronto[2]), .ErroEnd(erro_end[2]),
      .estado_dbg(dbg[2]));

   typedef struct packed {
      logic [31:0] due;
      logic [1:0]  inst;
      logic        err;
      logic [7:0]  data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic int lat_of(input int i);
      case (i)
         0:       return 1;
         1:       return 3;
         default: return 4;
      endcase
   endfunction

   function automatic int depth_of(input int i);
      return (i == 1) ? 200 : 16;
   endfunction

   function automatic int exp_rise(input int i);
      return CLR_EN ? depth_of(i) : 1;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (le_valido[i] === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_valid inst=%0d got LeValido=1 LeDado=%h, required no response", i, le_dado[i]);
            end else begin
               mon_e = exp_q.pop_front();
               if ((mon_e.inst == i[1:0]) && (le_dado[i] === mon_e.data) &&
                   (erro_end[i] === mon_e.err) && (cyc == mon_e.due)) begin
                  n_pass++;
               end else begin
                  $display("FAIL rd_resp inst=%0d cyc=%0d got data=%h err=%b, required inst=%0d data=%h err=%b cyc=%0d",
                           i, cyc, le_dado[i], erro_end[i], mon_e.inst, mon_e.data, mon_e.err, mon_e.due);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic issue(input int i, input logic we, input logic re,
                        input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_d, input logic exp_e);
      exp_t e;
      esc[i]  = we;
      ler[i]  = re;
      addr[i] = a;
      wdat[i] = d;
      if (re) begin
         e.due  = cyc + 1 + lat_of(i);
         e.inst = i[1:0];
         e.err  = exp_e;
         e.data = exp_d;
         exp_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int i);
      esc[i] = 1'b0;
      ler[i] = 1'b0;
   endtask

   task automatic wait_drain(input int i);
      repeat (lat_of(i) + 2) @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain inst=%0d got %0d pending responses, required 0", i, exp_q.size());
   endtask

   task automatic wait_ready(input int i);
      int n;
      n = 0;
      while ((pronto[i] !== 1'b1) && (n < 1000)) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (pronto[i] === 1'b1) n_pass++;
      else $display("FAIL ready_timeout inst=%0d got Pronto=%b, required 1", i, pronto[i]);
   endtask

   // Called at a negedge right after reset release; counts edges to Pronto.
   task automatic count_rise(input int i, output int cnt);
      cnt = 0;
      while ((pronto[i] !== 1'b1) && (cnt < 1000)) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int cnt;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; esc[i] = 1'b0; ler[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({le_dado[i], le_valido[i], pronto[i], erro_end[i]} === 11'b0) n_pass++;
         else $display("FAIL reset_outputs inst=%0d got LeDado=%h LeValido=%b Pronto=%b ErroEnd=%b, required all 0",
                       i, le_dado[i], le_valido[i], pronto[i], erro_end[i]);
      end
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      count_rise(0, cnt);
      n_checks++;
      if (cnt == exp_rise(0)) n_pass++;
      else $display("FAIL pronto_rise got %0d cycles, required %0d", cnt, exp_rise(0));
   endtask

   task automatic test_clear_contents();
`ifdef MEM_CLEAR_ON_RESET_EN
      for (int a = 0; a < 16; a++) issue(0, 1'b0, 1'b1, 8'(a), 8'h00, 8'h00, 1'b0);
`else
      for (int a = 0; a < 16; a++) issue(0, 1'b1, 1'b0, 8'(a), 8'(8'h30 + a), 8'h00, 1'b0);
      for (int a = 0; a < 16; a++) issue(0, 1'b0, 1'b1, 8'(a), 8'h00, 8'(8'h30 + a), 1'b0);
`endif
      idle(0);
      wait_drain(0);
   endtask

   task automatic test_basic_rw();
      issue(0, 1'b1, 1'b0, 8'd3, 8'hA5, 8'h00, 1'b0);
      issue(0, 1'b0, 1'b1, 8'd3, 8'h00, 8'hA5, 1'b0);
      idle(0);
      @(negedge clk);
      n_checks++;
      if ((le_valido[0] === 1'b1) && (le_dado[0] === 8'hA5)) n_pass++;
      else $display("FAIL basic_rd got LeValido=%b LeDado=%h, required 1 a5", le_valido[0], le_dado[0]);
      @(negedge clk);
      n_checks++;
      if ((le_valido[0] === 1'b0) && (le_dado[0] === 8'hA5)) n_pass++;
      else $display("FAIL basic_hold got LeValido=%b LeDado=%h, required 0 a5", le_valido[0], le_dado[0]);
      wait_drain(0);
   endtask

   task automatic test_read_before_write();
      issue(0, 1'b1, 1'b0, 8'd5, 8'h22, 8'h00, 1'b0);
      issue(0, 1'b1, 1'b1, 8'd5, 8'h77, 8'h22, 1'b0);
      issue(0, 1'b0, 1'b1, 8'd5, 8'h00, 8'h77, 1'b0);
      idle(0);
      wait_drain(0);
   endtask

   task automatic test_pipelined_reads();
      wait_ready(1);
      for (int k = 0; k < 4; k++) issue(1, 1'b1, 1'b0, 8'(k), 8'(8'h10 + k), 8'h00, 1'b0);
      for (int k = 0; k < 4; k++) issue(1, 1'b0, 1'b1, 8'(k), 8'h00, 8'(8'h10 + k), 1'b0);
      idle(1);
      wait_drain(1);
   endtask

   task automatic test_back_to_back();
      logic [7:0] d [6];
      for (int k = 0; k < 6; k++) begin
         d[k] = 8'($urandom_range(0, 255));
         issue(1, 1'b1, 1'b0, 8'(20 + k), d[k], 8'h00, 1'b0);
         issue(1, 1'b0, 1'b1, 8'(20 + k), 8'h00, d[k], 1'b0);
      end
      for (int k = 0; k < 6; k++) issue(1, 1'b0, 1'b1, 8'(20 + k), 8'h00, d[k], 1'b0);
      idle(1);
      wait_drain(1);
   endtask

   task automatic test_out_of_range();
      issue(1, 1'b1, 1'b0, 8'd50,  8'h5A, 8'h00, 1'b0);
      issue(1, 1'b1, 1'b0, 8'd122, 8'hC3, 8'h00, 1'b0);
      issue(1, 1'b1, 1'b0, 8'd199, 8'h3E, 8'h00, 1'b0);
      issue(1, 1'b1, 1'b0, 8'd250, 8'hFF, 8'h00, 1'b0);
      idle(1);
      n_checks++;
      if (erro_end[1] === 1'b0) n_pass++;
      else $display("FAIL oor_wr_early got ErroEnd=%b, required 0", erro_end[1]);
      @(negedge clk);
      n_checks++;
      if (erro_end[1] === 1'b1) n_pass++;
      else $display("FAIL oor_wr_pulse got ErroEnd=%b, required 1", erro_end[1]);
      @(negedge clk);
      n_checks++;
      if (erro_end[1] === 1'b0) n_pass++;
      else $display("FAIL oor_wr_end got ErroEnd=%b, required 0", erro_end[1]);
      issue(1, 1'b0, 1'b1, 8'd50,  8'h00, 8'h5A, 1'b0);
      issue(1, 1'b0, 1'b1, 8'd122, 8'h00, 8'hC3, 1'b0);
      issue(1, 1'b0, 1'b1, 8'd199, 8'h00, 8'h3E, 1'b0);
      issue(1, 1'b0, 1'b1, 8'd250, 8'h00, 8'h00, 1'b1);
      issue(1, 1'b0, 1'b1, 8'd200, 8'h00, 8'h00, 1'b1);
      idle(1);
      wait_drain(1);
   endtask

   task automatic test_reset_midop();
      int cnt;
      wait_ready(2);
      issue(2, 1'b1, 1'b0, 8'd7, 8'h9C, 8'h00, 1'b0);
      issue(2, 1'b0, 1'b1, 8'd7, 8'h00, 8'h9C, 1'b0);
      idle(2);
      wait_drain(2);
      // second read is still in flight when reset hits mid-cycle
      issue(2, 1'b0, 1'b1, 8'd7, 8'h00, 8'h9C, 1'b0);
      idle(2);
      @(posedge clk);
      #2;
      rst[2] = 1'b1;
      #1;
      n_checks++;
      if ({le_dado[2], le_valido[2], pronto[2], erro_end[2]} === 11'b0) n_pass++;
      else $display("FAIL midop_reset got LeDado=%h LeValido=%b Pronto=%b ErroEnd=%b, required all 0",
                    le_dado[2], le_valido[2], pronto[2], erro_end[2]);
      exp_q.delete();
      repeat (6) @(negedge clk);
      rst[2] = 1'b0;
      count_rise(2, cnt);
      n_checks++;
      if (cnt == exp_rise(2)) n_pass++;
      else $display("FAIL midop_rise got %0d cycles, required %0d", cnt, exp_rise(2));
      // reset again part way through the (possible) clear sequence
      rst[2] = 1'b1;
      @(negedge clk);
      rst[2] = 1'b0;
      repeat (5) @(negedge clk);
      rst[2] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pronto[2] === 1'b0) n_pass++;
      else $display("FAIL clear_reset_pronto got Pronto=%b, required 0", pronto[2]);
      rst[2] = 1'b0;
      count_rise(2, cnt);
      n_checks++;
      if (cnt == exp_rise(2)) n_pass++;
      else $display("FAIL clear_restart_rise got %0d cycles, required %0d", cnt, exp_rise(2));
      issue(2, 1'b0, 1'b1, 8'd7, 8'h00, CLR_EN ? 8'h00 : 8'h9C, 1'b0);
      idle(2);
      wait_drain(2);
   endtask

   initial begin
      test_reset();
      test_clear_contents();
      test_basic_rw();
      test_read_before_write();
      test_pipelined_reads();
      test_back_to_back();
      test_out_of_range();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
